// File: rtl/register_access_pkg.sv
// Shared types for the register access arbiter.
//   req_id_t : which requester owns a slot or a read response
//   op_t     : write or read operation
//   N_REQ    : number of requesters sharing the register-block port
package register_access_pkg;

    typedef enum logic {REQ_A, REQ_B} req_id_t;
    typedef enum logic {OP_WRITE, OP_READ} op_t;

    localparam int N_REQ = 2;

endpackage

// File: rtl/request_slot.sv
// One-deep holding register for a single requester operation.
// Ports:
//   clk, i_reset       : clock, synchronous active-high reset
//   load               : strobe from the requester
//   load_addr/load_data: payload captured on an accepted load
//   grant              : arbiter is issuing this slot this cycle
//   valid, addr, data  : current slot contents
//   drop               : load rejected because the slot is full and not draining
module request_slot
    import register_access_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  i_reset,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [WIDTH-1:0]      load_data,
    input  logic                  grant,
    output logic                  valid,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [WIDTH-1:0]      data,
    output logic                  drop
);

    // A slot being granted this cycle frees up in time to take a new strobe.
    logic accept;
    assign accept = load && (!valid || grant);
    assign drop   = load && valid && !grant;

    always_ff @(posedge clk) begin
        if (i_reset) begin
            valid <= 1'b0;
        end else if (accept) begin
            valid <= 1'b1;
        end else if (grant) begin
            valid <= 1'b0;
        end
    end

    // NOTE: payload registers are not reset; valid alone qualifies them.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr <= load_addr;
            data <= load_data;
        end
    end

endmodule

// File: rtl/register_access_arbiter.sv
// Shares the single write/read port of the register block between requester A
// (UART command parser) and requester B (second on-chip master).
// Ports:
//   clk, i_reset                      : clock, synchronous active-high reset
//   i_X_w_en/_w_addr/_w_value         : write strobe from requester X (a/b)
//   i_X_r_en/_r_addr                  : read strobe from requester X
//   o_X_r_value/_r_valid              : read response routed back to requester X
//   o_m_w_en/_w_addr/_w_value         : write issued to the register block
//   o_m_r_en/_r_addr                  : read issued to the register block
//   i_m_r_value/_r_valid              : register block response, one cycle after o_m_r_en
//   o_overflow                        : sticky drop flags, bit 0 = A, bit 1 = B
//   i_clear_overflow                  : clears o_overflow (a same-cycle drop wins)
module register_access_arbiter
    import register_access_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  i_reset,

    input  logic                  i_a_w_en,
    input  logic [ADDR_WIDTH-1:0] i_a_w_addr,
    input  logic [WIDTH-1:0]      i_a_w_value,
    input  logic                  i_a_r_en,
    input  logic [ADDR_WIDTH-1:0] i_a_r_addr,
    output logic [WIDTH-1:0]      o_a_r_value,
    output logic                  o_a_r_valid,

    input  logic                  i_b_w_en,
    input  logic [ADDR_WIDTH-1:0] i_b_w_addr,
    input  logic [WIDTH-1:0]      i_b_w_value,
    input  logic                  i_b_r_en,
    input  logic [ADDR_WIDTH-1:0] i_b_r_addr,
    output logic [WIDTH-1:0]      o_b_r_value,
    output logic                  o_b_r_valid,

    output logic                  o_m_w_en,
    output logic [ADDR_WIDTH-1:0] o_m_w_addr,
    output logic [WIDTH-1:0]      o_m_w_value,
    output logic                  o_m_r_en,
    output logic [ADDR_WIDTH-1:0] o_m_r_addr,
    input  logic [WIDTH-1:0]      i_m_r_value,
    input  logic                  i_m_r_valid,

    output logic [N_REQ-1:0]      o_overflow,
    input  logic                  i_clear_overflow
);

    // Slot index is {requester, op}: 0 = A write, 1 = A read, 2 = B write, 3 = B read.
    logic [3:0]            slot_load;
    logic [3:0]            slot_grant;
    logic [3:0]            slot_valid;
    logic [3:0]            slot_drop;
    logic [ADDR_WIDTH-1:0] slot_load_addr [4];
    logic [WIDTH-1:0]      slot_load_data [4];
    logic [ADDR_WIDTH-1:0] slot_addr      [4];
    logic [WIDTH-1:0]      slot_data      [4];

    assign slot_load         = {i_b_r_en, i_b_w_en, i_a_r_en, i_a_w_en};
    assign slot_load_addr[0] = i_a_w_addr;
    assign slot_load_addr[1] = i_a_r_addr;
    assign slot_load_addr[2] = i_b_w_addr;
    assign slot_load_addr[3] = i_b_r_addr;
    assign slot_load_data[0] = i_a_w_value;
    assign slot_load_data[1] = '0;
    assign slot_load_data[2] = i_b_w_value;
    assign slot_load_data[3] = '0;

    for (genvar i = 0; i < 4; i++) begin : g_slot
        request_slot #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .WIDTH      (WIDTH)
        ) u_slot (
            .clk       (clk),
            .i_reset   (i_reset),
            .load      (slot_load[i]),
            .load_addr (slot_load_addr[i]),
            .load_data (slot_load_data[i]),
            .grant     (slot_grant[i]),
            .valid     (slot_valid[i]),
            .addr      (slot_addr[i]),
            .data      (slot_data[i]),
            .drop      (slot_drop[i])
        );
    end

    req_id_t          rr_ptr;
    logic             owner_valid;
    req_id_t          owner_id;
    logic [N_REQ-1:0] overflow_q;

    logic    pend_a, pend_b;
    logic    any_grant;
    req_id_t win;
    op_t     win_op;
    logic [1:0] sel;

    assign pend_a = slot_valid[0] | slot_valid[1];
    assign pend_b = slot_valid[2] | slot_valid[3];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        any_grant   = 1'b0;
        win         = rr_ptr;
        slot_grant  = '0;
        o_m_w_en    = 1'b0;
        o_m_w_addr  = '0;
        o_m_w_value = '0;
        o_m_r_en    = 1'b0;
        o_m_r_addr  = '0;

        // Nothing is issued while reset is held, even if slots still look full.
        if (!i_reset) begin
            if (pend_a && pend_b) begin
                any_grant = 1'b1;
                win       = rr_ptr;
            end else if (pend_a) begin
                any_grant = 1'b1;
                win       = REQ_A;
            end else if (pend_b) begin
                any_grant = 1'b1;
                win       = REQ_B;
            end
        end

        // Write before read keeps a same-cycle write+read coherent.
        win_op = slot_valid[{win, OP_WRITE}] ? OP_WRITE : OP_READ;
        sel    = {win, win_op};

        if (any_grant) begin
            slot_grant[sel] = 1'b1;
            if (win_op == OP_WRITE) begin
                o_m_w_en    = 1'b1;
                o_m_w_addr  = slot_addr[sel];
                o_m_w_value = slot_data[sel];
            end else begin
                o_m_r_en    = 1'b1;
                o_m_r_addr  = slot_addr[sel];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            rr_ptr      <= REQ_A;
            owner_valid <= 1'b0;
            owner_id    <= REQ_A;
            overflow_q  <= '0;
        end else begin
            if (any_grant) begin
                rr_ptr   <= (win == REQ_A) ? REQ_B : REQ_A;
                owner_id <= win;
            end
            // The register block answers exactly one cycle later, so ownership
            // only needs to live for one cycle.
            owner_valid <= any_grant && (win_op == OP_READ);
            overflow_q  <= (overflow_q & ~{N_REQ{i_clear_overflow}})
                         | {slot_drop[2] | slot_drop[3], slot_drop[0] | slot_drop[1]};
        end
    end

    assign o_a_r_valid = !i_reset && i_m_r_valid && owner_valid && (owner_id == REQ_A);
    assign o_b_r_valid = !i_reset && i_m_r_valid && owner_valid && (owner_id == REQ_B);
    assign o_a_r_value = o_a_r_valid ? i_m_r_value : '0;
    assign o_b_r_value = o_b_r_valid ? i_m_r_value : '0;
    assign o_overflow  = i_reset ? '0 : overflow_q;

endmodule

// File: tb/tb_register_access_arbiter.sv
// Self-checking bench for register_access_arbiter: directed scenarios followed
// by random traffic, all compared against a behavioural model of the slots,
// round-robin pointer, read ownership and overflow flags. The bench also plays
// the register block (storage plus one-cycle read response).
module tb_register_access_arbiter;

    logic        clk;
    logic        i_reset;
    logic        i_a_w_en, i_a_r_en, i_b_w_en, i_b_r_en;
    logic [7:0]  i_a_w_addr, i_a_r_addr, i_b_w_addr, i_b_r_addr;
    logic [31:0] i_a_w_value, i_b_w_value;
    logic [31:0] o_a_r_value, o_b_r_value;
    logic        o_a_r_valid, o_b_r_valid;
    logic        o_m_w_en, o_m_r_en;
    logic [7:0]  o_m_w_addr, o_m_r_addr;
    logic [31:0] o_m_w_value;
    logic [31:0] i_m_r_value;
    logic        i_m_r_valid;
    logic [1:0]  o_overflow;
    logic        i_clear_overflow;

    register_access_arbiter #(.WIDTH(32), .ADDR_WIDTH(8)) dut (
        .clk              (clk),
        .i_reset          (i_reset),
        .i_a_w_en         (i_a_w_en),
        .i_a_w_addr       (i_a_w_addr),
        .i_a_w_value      (i_a_w_value),
        .i_a_r_en         (i_a_r_en),
        .i_a_r_addr       (i_a_r_addr),
        .o_a_r_value      (o_a_r_value),
        .o_a_r_valid      (o_a_r_valid),
        .i_b_w_en         (i_b_w_en),
        .i_b_w_addr       (i_b_w_addr),
        .i_b_w_value      (i_b_w_value),
        .i_b_r_en         (i_b_r_en),
        .i_b_r_addr       (i_b_r_addr),
        .o_b_r_value      (o_b_r_value),
        .o_b_r_valid      (o_b_r_valid),
        .o_m_w_en         (o_m_w_en),
        .o_m_w_addr       (o_m_w_addr),
        .o_m_w_value      (o_m_w_value),
        .o_m_r_en         (o_m_r_en),
        .o_m_r_addr       (o_m_r_addr),
        .i_m_r_value      (i_m_r_value),
        .i_m_r_valid      (i_m_r_valid),
        .o_overflow       (o_overflow),
        .i_clear_overflow (i_clear_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    // Reference model: pend[req][op] with op 0 = write, 1 = read.
    bit          pend      [2][2];
    logic [7:0]  pend_addr [2][2];
    logic [31:0] pend_data [2];
    int          rr;
    bit          own_v;
    int          own_id;
    logic [31:0] own_val;
    logic [1:0]  ov;
    logic [31:0] ref_mem [256];

    // Register-block environment.
    logic [31:0] rb_mem [256];
    bit          env_rv;
    logic [31:0] env_rval;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        i_a_w_en = 1'b0; i_a_r_en = 1'b0; i_b_w_en = 1'b0; i_b_r_en = 1'b0;
        i_clear_overflow = 1'b0;
        i_reset = 1'b0;
    endtask

    // Checks one cycle against the model, advances the model and the register
    // block, then returns at the next falling edge with strobes cleared.
    task automatic tick();
        bit          st [2][2];
        logic [7:0]  st_addr [2][2];
        logic [31:0] st_data [2];
        bit          granted;
        int          win, op;
        bit          e_wen, e_ren;
        logic [7:0]  e_waddr, e_raddr;
        logic [31:0] e_wval;
        bit          e_rv [2];
        logic [1:0]  e_ov;

        #1;
        st[0][0] = i_a_w_en; st[0][1] = i_a_r_en; st[1][0] = i_b_w_en; st[1][1] = i_b_r_en;
        st_addr[0][0] = i_a_w_addr; st_addr[0][1] = i_a_r_addr;
        st_addr[1][0] = i_b_w_addr; st_addr[1][1] = i_b_r_addr;
        st_data[0] = i_a_w_value; st_data[1] = i_b_w_value;

        granted = 1'b0; win = 0; op = 0;
        e_wen = 1'b0; e_ren = 1'b0; e_waddr = '0; e_raddr = '0; e_wval = '0;
        e_rv[0] = 1'b0; e_rv[1] = 1'b0; e_ov = 2'b00;
        if (!i_reset) begin
            bit has_a, has_b;
            has_a = pend[0][0] || pend[0][1];
            has_b = pend[1][0] || pend[1][1];
            granted = has_a || has_b;
            win = (has_a && has_b) ? rr : (has_a ? 0 : 1);
            op  = pend[win][0] ? 0 : 1;
            if (granted && op == 0) begin
                e_wen = 1'b1; e_waddr = pend_addr[win][0]; e_wval = pend_data[win];
            end
            if (granted && op == 1) begin
                e_ren = 1'b1; e_raddr = pend_addr[win][1];
            end
            e_rv[0] = i_m_r_valid && own_v && own_id == 0;
            e_rv[1] = i_m_r_valid && own_v && own_id == 1;
            e_ov = ov;
        end

        check("m_w_en",    o_m_w_en,    e_wen);
        check("m_w_addr",  o_m_w_addr,  e_waddr);
        check("m_w_value", o_m_w_value, e_wval);
        check("m_r_en",    o_m_r_en,    e_ren);
        check("m_r_addr",  o_m_r_addr,  e_raddr);
        check("a_r_valid", o_a_r_valid, e_rv[0]);
        check("a_r_value", o_a_r_value, e_rv[0] ? own_val : 32'h0);
        check("b_r_valid", o_b_r_valid, e_rv[1]);
        check("b_r_value", o_b_r_value, e_rv[1] ? own_val : 32'h0);
        check("overflow",  o_overflow,  e_ov);

        if (i_reset) begin
            for (int r = 0; r < 2; r++) begin
                pend[r][0] = 1'b0;
                pend[r][1] = 1'b0;
            end
            rr = 0; own_v = 1'b0; ov = 2'b00;
        end else begin
            own_v = 1'b0;
            if (granted) begin
                pend[win][op] = 1'b0;
                if (op == 0) ref_mem[pend_addr[win][0]] = pend_data[win];
                else begin
                    own_v   = 1'b1;
                    own_id  = win;
                    own_val = ref_mem[pend_addr[win][1]];
                end
                rr = 1 - win;
            end
            if (i_clear_overflow) ov = 2'b00;
            for (int r = 0; r < 2; r++) begin
                for (int o = 0; o < 2; o++) begin
                    if (st[r][o]) begin
                        if (pend[r][o]) ov[r] = 1'b1;
                        else begin
                            pend[r][o] = 1'b1;
                            pend_addr[r][o] = st_addr[r][o];
                            if (o == 0) pend_data[r] = st_data[r];
                        end
                    end
                end
            end
        end

        env_rv   = o_m_r_en;
        env_rval = rb_mem[o_m_r_addr];
        if (o_m_w_en) rb_mem[o_m_w_addr] = o_m_w_value;

        @(negedge clk);
        clear_inputs();
        i_m_r_valid = env_rv;
        i_m_r_value = env_rv ? env_rval : 32'h0;
    endtask

    initial begin
        clear_inputs();
        i_a_w_addr = '0; i_a_r_addr = '0; i_b_w_addr = '0; i_b_r_addr = '0;
        i_a_w_value = '0; i_b_w_value = '0;
        i_m_r_valid = 1'b0; i_m_r_value = '0;
        env_rv = 1'b0; env_rval = '0;
        own_v = 1'b0; own_id = 0; own_val = '0; rr = 0; ov = 2'b00;
        for (int r = 0; r < 2; r++) begin
            pend[r][0] = 1'b0; pend[r][1] = 1'b0;
            pend_addr[r][0] = '0; pend_addr[r][1] = '0; pend_data[r] = '0;
        end
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = (i * 32'h01010101) ^ 32'h5A5A0000;
            rb_mem[i]  = ref_mem[i];
        end

        // Reset.
        i_reset = 1'b1; tick();
        i_reset = 1'b1; tick();
        tick();

        // A writes 0x03 = 0xDEADBEEF.
        i_a_w_en = 1'b1; i_a_w_addr = 8'h03; i_a_w_value = 32'hDEADBEEF; tick();
        #1;
        check("wr_en_t1",   o_m_w_en,    1'b1);
        check("wr_addr_t1", o_m_w_addr,  8'h03);
        check("wr_val_t1",  o_m_w_value, 32'hDEADBEEF);
        check("wr_no_rd",   o_m_r_en,    1'b0);
        tick();

        // A reads 0x03 back.
        i_a_r_en = 1'b1; i_a_r_addr = 8'h03; tick();
        #1;
        check("rd_en_t1",   o_m_r_en,   1'b1);
        check("rd_addr_t1", o_m_r_addr, 8'h03);
        tick();
        #1;
        check("rd_valid_t2", o_a_r_valid, 1'b1);
        check("rd_value_t2", o_a_r_value, 32'hDEADBEEF);
        check("rd_b_quiet",  o_b_r_valid, 1'b0);
        tick();

        // Same-cycle writes from A and B right after reset: A first.
        i_reset = 1'b1; tick();
        i_a_w_en = 1'b1; i_a_w_addr = 8'h01; i_a_w_value = 32'h11;
        i_b_w_en = 1'b1; i_b_w_addr = 8'h02; i_b_w_value = 32'h22;
        tick();
        #1 check("cont_first",  o_m_w_addr, 8'h01);
        tick();
        #1 check("cont_second", o_m_w_addr, 8'h02);
        tick();

        // Same-cycle write and read to one address by A.
        i_a_w_en = 1'b1; i_a_w_addr = 8'h05; i_a_w_value = 32'hCAFE0000;
        i_a_r_en = 1'b1; i_a_r_addr = 8'h05;
        tick();
        #1 check("wr_first", o_m_w_en, 1'b1);
        tick();
        #1 check("rd_second", o_m_r_en, 1'b1);
        tick();
        #1 check("wr_rd_value", o_a_r_value, 32'hCAFE0000);
        tick();

        // B overflows while A keeps its slot draining.
        i_reset = 1'b1; tick();
        i_a_w_en = 1'b1; i_a_w_addr = 8'h10; i_a_w_value = 32'h1;
        i_b_w_en = 1'b1; i_b_w_addr = 8'h20; i_b_w_value = 32'h1;
        tick();
        i_a_w_en = 1'b1; i_a_w_addr = 8'h11; i_a_w_value = 32'h2;
        i_b_w_en = 1'b1; i_b_w_addr = 8'h21; i_b_w_value = 32'h2;
        tick();
        #1 check("ovf_set", o_overflow, 2'b10);
        i_b_w_en = 1'b1; i_b_w_addr = 8'h22; i_b_w_value = 32'h3;
        tick();
        tick(); tick();
        i_clear_overflow = 1'b1; tick();
        #1 check("ovf_clear", o_overflow, 2'b00);
        tick();

        // Fill all four slots, reset before any grant.
        i_a_w_en = 1'b1; i_a_r_en = 1'b1; i_b_w_en = 1'b1; i_b_r_en = 1'b1;
        tick();
        i_reset = 1'b1; tick();
        for (int k = 0; k < 4; k++) begin
            #1;
            check("flush_no_w",  o_m_w_en,    1'b0);
            check("flush_no_r",  o_m_r_en,    1'b0);
            check("flush_no_rv", o_a_r_valid | o_b_r_valid, 1'b0);
            check("flush_ovf",   o_overflow,  2'b00);
            tick();
        end

        // Reset lands on the cycle the read response arrives.
        i_b_r_en = 1'b1; i_b_r_addr = 8'h03; tick();
        tick();
        i_reset = 1'b1; tick();
        tick();

        // Random traffic on a small address window to provoke collisions.
        for (int n = 0; n < 600; n++) begin
            i_a_w_en = ($urandom_range(2) == 0);
            i_a_r_en = ($urandom_range(2) == 0);
            i_b_w_en = ($urandom_range(2) == 0);
            i_b_r_en = ($urandom_range(2) == 0);
            i_a_w_addr = 8'($urandom_range(7)); i_a_r_addr = 8'($urandom_range(7));
            i_b_w_addr = 8'($urandom_range(7)); i_b_r_addr = 8'($urandom_range(7));
            i_a_w_value = $urandom; i_b_w_value = $urandom;
            i_clear_overflow = ($urandom_range(15) == 0);
            i_reset = ($urandom_range(59) == 0);
            // Stray response with no read outstanding must be ignored.
            if (!i_m_r_valid && $urandom_range(7) == 0) begin
                i_m_r_valid = 1'b1;
                i_m_r_value = $urandom;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
